// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL channel types used by the host driver
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    localparam tl_a_user_t TL_A_USER_DEFAULT = '{cmd_intg: 7'h0, data_intg: 7'h0};

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        tl_a_user_t        a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_host_driver.sv
// rtl/tlul_host_driver.sv - single-outstanding TL-UL host turning register commands into A/D transactions
module tlul_host_driver #(
    parameter logic [tlul_pkg::TL_AIW-1:0] SourceId      = '0,
    parameter int unsigned                 TimeoutCycles = 1024,
    parameter int unsigned                 CntW          = $clog2(TimeoutCycles + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [31:0]       cmd_addr_i,
    input  logic [31:0]       cmd_wdata_i,
    input  logic [3:0]        cmd_mask_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic              spurious_o,
    output tlul_pkg::tl_h2d_t tl_o,
    input  tlul_pkg::tl_d2h_t tl_i
);
    import tlul_pkg::*;

    typedef enum logic [1:0] {
        IDLE,
        A_REQ,
        D_WAIT,
        RSP
    } state_e;

    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    state_e          state_q, state_d;
    logic            write_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      mask_q;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic            timeout_q;
    logic            spurious_q;

    tl_d_op_e        exp_d_op;
    logic            d_err;

    logic unused_d_fields;
    assign unused_d_fields = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink};

    always_comb begin
        exp_d_op = AccessAckData;
        if (write_q) begin
            exp_d_op = AccessAck;
        end
        d_err = tl_i.d_error | (tl_i.d_source != SourceId) | (tl_i.d_opcode != exp_d_op);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid_i) state_d = A_REQ;
            A_REQ:   if (tl_i.a_ready) state_d = D_WAIT;
            D_WAIT:  if (tl_i.d_valid || (cnt_q == CntLast)) state_d = RSP;
            RSP:     if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A fields come straight from the latched command so they stay put until a_ready.
    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = !rst_i && (state_q == A_REQ);
        tl_o.a_param   = 3'h0;
        tl_o.a_size    = 2'd2;
        tl_o.a_source  = SourceId;
        tl_o.a_address = {addr_q[31:2], 2'b00};
        tl_o.a_user    = TL_A_USER_DEFAULT;
        if (write_q) begin
            tl_o.a_mask = mask_q;
            tl_o.a_data = wdata_q;
            if (mask_q == 4'hF) begin
                tl_o.a_opcode = PutFullData;
            end else begin
                tl_o.a_opcode = PutPartialData;
            end
        end else begin
            tl_o.a_mask   = 4'hF;
            tl_o.a_data   = '0;
            tl_o.a_opcode = Get;
        end
        tl_o.d_ready = !rst_i && ((state_q == IDLE) || (state_q == D_WAIT));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            spurious_q <= tl_i.d_valid && ((state_q == IDLE) || (state_q == RSP));
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        write_q <= cmd_write_i;
                        addr_q  <= cmd_addr_i;
                        wdata_q <= cmd_wdata_i;
                        mask_q  <= cmd_mask_i;
                    end
                end
                A_REQ: begin
                    if (tl_i.a_ready) begin
                        cnt_q <= '0;
                    end
                end
                D_WAIT: begin
                    // A beat arriving on the expiry cycle still counts as the response.
                    if (tl_i.d_valid) begin
                        err_q     <= d_err;
                        timeout_q <= 1'b0;
                        rdata_q   <= (!write_q && !d_err) ? tl_i.d_data : 32'h0;
                    end else if (cnt_q == CntLast) begin
                        err_q     <= 1'b1;
                        timeout_q <= 1'b1;
                        rdata_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        rdata_q   <= '0;
                        err_q     <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cmd_ready_o   = !rst_i && (state_q == IDLE);
    assign rsp_valid_o   = (state_q == RSP);
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = timeout_q;
    assign spurious_o    = spurious_q;

endmodule

// File: tb/tb_tlul_host_driver.sv
// tb/tb_tlul_host_driver.sv - randomized scoreboard bench for the TL-UL host driver
module tb_tlul_host_driver;
    import tlul_pkg::*;

    localparam logic [TL_AIW-1:0] Src = 8'h03;
    localparam int                Tmo = 8;

    localparam int M_OK   = 0;
    localparam int M_DERR = 1;
    localparam int M_SRC  = 2;
    localparam int M_OPC  = 3;
    localparam int M_TMO  = 4;
    localparam int M_LATE = 5;
    localparam int M_RST  = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_mask;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout, spurious;
    tl_h2d_t     tl_h2d;
    tl_d2h_t     tl_d2h;

    tlul_host_driver #(.SourceId(Src), .TimeoutCycles(Tmo)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_mask_i(cmd_mask),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout), .spurious_o(spurious),
        .tl_o(tl_h2d), .tl_i(tl_d2h)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ddata;
        logic [3:0]  mask;
        int          a_dly;
        int          d_dly;
        int          mode;
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          acc;
        int          lat;
    } rsp_t;

    txn_t dev_q[$];
    rsp_t exp_q[$];
    int   n_issued = 0, n_dev_done = 0, n_ahs = 0;
    int   exp_spur = 0, n_spur = 0;
    int   n_checks = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        $display("FAIL %s: wait bound expired, event seen 0 want 1 (t=%0t)", name, $time);
    endtask

    function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] m, input int ad, input int dd,
                                input int md, input logic [31:0] dd_data);
        txn_t t;
        t.write = w; t.addr = a; t.wdata = wd; t.mask = m;
        t.a_dly = ad; t.d_dly = dd; t.mode = md; t.ddata = dd_data;
        return t;
    endfunction

    // Device model: accepts A after a_dly cycles of a_valid, answers per mode.
    initial begin : device
        txn_t        t;
        int          seen;
        bit          done;
        int          g;
        logic [31:0] exp_op, exp_mask, exp_data;
        tl_d2h = '0;
        forever begin
            @(posedge clk); #1;
            if (dev_q.size() == 0) continue;
            t = dev_q.pop_front();
            exp_op   = !t.write ? 32'd4 : ((t.mask == 4'hF) ? 32'd0 : 32'd1);
            exp_mask = t.write ? {28'h0, t.mask} : 32'hF;
            exp_data = t.write ? t.wdata : 32'h0;
            seen = 0;
            done = 0;
            for (int c = 0; c < 100 && !done; c++) begin
                tl_d2h.a_ready = (seen >= t.a_dly);
                @(negedge clk);
                if (tl_h2d.a_valid) begin
                    check("a_opcode", 32'(tl_h2d.a_opcode), exp_op);
                    check("a_address", tl_h2d.a_address, {t.addr[31:2], 2'b00});
                    check("a_mask", 32'(tl_h2d.a_mask), exp_mask);
                    check("a_data", tl_h2d.a_data, exp_data);
                    check("a_param_size_source",
                          32'({tl_h2d.a_param, tl_h2d.a_size, tl_h2d.a_source}),
                          32'({3'h0, 2'd2, Src}));
                    if (tl_d2h.a_ready) done = 1;
                    else seen++;
                end
                @(posedge clk); #1;
            end
            tl_d2h.a_ready = 1'b0;
            if (!done) bound_fail("a_handshake");
            n_ahs++;
            if (t.mode <= M_OPC) begin
                repeat (t.d_dly) begin @(posedge clk); #1; end
                tl_d2h.d_valid  = 1'b1;
                tl_d2h.d_data   = t.ddata;
                tl_d2h.d_error  = (t.mode == M_DERR);
                tl_d2h.d_source = (t.mode == M_SRC) ? Src + 8'd1 : Src;
                if (t.write ^ (t.mode == M_OPC)) tl_d2h.d_opcode = AccessAck;
                else tl_d2h.d_opcode = AccessAckData;
                @(negedge clk);
                check("d_ready", 32'(tl_h2d.d_ready), 32'd1);
                @(posedge clk); #1;
                tl_d2h.d_valid = 1'b0;
                tl_d2h.d_error = 1'b0;
            end else if (t.mode == M_LATE || t.mode == M_RST) begin
                g = 0;
                if (t.mode == M_LATE) begin
                    do begin @(negedge clk); g++; end while (!rsp_valid && g < 100);
                    do begin @(negedge clk); g++; end while (rsp_valid && g < 300);
                end else begin
                    do begin @(negedge clk); g++; end while (!rst && g < 100);
                    do begin @(negedge clk); g++; end while (rst && g < 300);
                end
                if (g >= 300) bound_fail("late_beat_window");
                @(posedge clk); #1;
                tl_d2h.d_valid  = 1'b1;
                tl_d2h.d_source = Src;
                tl_d2h.d_data   = t.ddata;
                tl_d2h.d_opcode = AccessAckData;
                @(posedge clk); #1;
                tl_d2h.d_valid = 1'b0;
            end
            n_dev_done++;
        end
    end

    // Response monitor / scoreboard with random backpressure.
    initial begin : monitor
        rsp_t e;
        bit   first_seen;
        first_seen = 0;
        rsp_ready  = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_valid_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q[0];
                    if (!first_seen) check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                    first_seen = 1;
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        first_seen = 0;
                    end
                end
            end
            @(posedge clk); #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) if (spurious === 1'b1) n_spur <= n_spur + 1;

    task automatic wait_quiet();
        int g;
        g = 0;
        while ((n_issued != n_dev_done || exp_q.size() != 0) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) bound_fail("idle_wait");
    endtask

    task automatic issue(input txn_t t);
        rsp_t e;
        int   g;
        wait_quiet();
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_write = t.write;
        cmd_addr  = t.addr;
        cmd_wdata = t.wdata;
        cmd_mask  = t.mask;
        g = 0;
        do begin @(negedge clk); g++; end while (!cmd_ready && g < 50);
        if (!cmd_ready) begin
            bound_fail("cmd_ready");
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            return;
        end
        e.tmo   = (t.mode == M_TMO || t.mode == M_LATE);
        e.err   = (t.mode != M_OK);
        e.rdata = (!t.write && t.mode == M_OK) ? t.ddata : 32'h0;
        e.acc   = cyc + 1;
        e.lat   = 2 + t.a_dly + (e.tmo ? Tmo - 1 : t.d_dly);
        dev_q.push_back(t);
        n_issued++;
        if (t.mode != M_RST) exp_q.push_back(e);
        if (t.mode == M_LATE || t.mode == M_RST) exp_spur++;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        check({tag, "_a_valid"}, 32'(tl_h2d.a_valid), 32'd0);
        check({tag, "_d_ready"}, 32'(tl_h2d.d_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        check({tag, "_err_tmo_spur"}, 32'({rsp_err, rsp_timeout, spurious}), 32'd0);
    endtask

    initial begin : stimulus
        txn_t t;
        int   r, prev, g;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_d_ready", 32'(tl_h2d.d_ready), 32'd1);

        issue(mk(1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 0, 0, M_OK, 32'hA5A5_5A5A));
        issue(mk(1'b0, 32'h0000_0027, 32'h0, 4'h0, 0, 0, M_OK, 32'h1234_5678));
        issue(mk(1'b1, 32'h0000_0104, 32'hCAFE_F00D, 4'b0011, 5, 1, M_OK, 32'h0));
        issue(mk(1'b0, 32'h0000_0200, 32'h0, 4'h0, 0, 2, M_DERR, 32'h5555_AAAA));
        issue(mk(1'b0, 32'h0000_0204, 32'h0, 4'h0, 1, 0, M_SRC, 32'h7777_8888));
        issue(mk(1'b1, 32'h0000_0208, 32'h1, 4'hF, 0, 0, M_OPC, 32'h0));
        issue(mk(1'b0, 32'h0000_020C, 32'h0, 4'h0, 0, Tmo - 1, M_OK, 32'h0BAD_CAFE));
        issue(mk(1'b0, 32'h0000_0300, 32'h0, 4'h0, 0, 0, M_LATE, 32'hFEED_BEEF));

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            t.write = $urandom_range(0, 1);
            t.addr  = $urandom;
            t.wdata = $urandom;
            t.ddata = $urandom;
            t.mask  = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            t.a_dly = $urandom_range(0, 3);
            t.d_dly = $urandom_range(0, Tmo - 1);
            t.mode  = (r <= 4) ? M_OK : (r == 5) ? M_DERR : (r == 6) ? M_SRC :
                      (r == 7) ? M_OPC : (r == 8) ? M_TMO : M_LATE;
            issue(t);
        end

        prev = n_ahs;
        issue(mk(1'b0, 32'h0000_0400, 32'h0, 4'h0, 0, 0, M_RST, 32'h1111_2222));
        g = 0;
        while (n_ahs == prev && g < 50) begin @(negedge clk); g++; end
        if (n_ahs == prev) bound_fail("rst_test_a_handshake");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        wait_quiet();
        repeat (6) @(negedge clk);
        check("spurious_count", 32'(n_spur), 32'(exp_spur));
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tlul_host_driver.md
Name: tlul_host_driver

Overview:
- Single-outstanding TL-UL host (initiator) that turns simple register read/write commands into TL-UL A-channel requests and returns D-channel responses.
- Drives the device-side `tl_i` / `tl_o` of KMAC (and other TL-UL peripherals) from fuzzing or directed stimulus engines.
- Handles protocol hold rules, response checking and response timeout.

Parameters:
- SourceId, 0, value driven on `a_source` and expected on `d_source` (width TL_AIW).
- TimeoutCycles, 1024, D-channel wait cycles before the transaction is abandoned (min 2).
- CntW, $clog2(TimeoutCycles+1), timeout counter width (derived).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_write_i  in  1  1=write, 0=read
- cmd_addr_i  in  32  byte address; bits [1:0] forced to 0 on the bus
- cmd_wdata_i  in  32  write data
- cmd_mask_i  in  4  byte enables (writes only; reads use 4'hF)
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  32  read data (0 for writes, errors and timeouts)
- rsp_err_o  out  1  d_error, opcode mismatch, source mismatch or timeout
- rsp_timeout_o  out  1  response was a timeout
- spurious_o  out  1  one-cycle pulse: D beat received in IDLE/RSP
- tl_o  out  tlul_pkg::tl_h2d_t  A-channel request plus d_ready
- tl_i  in  tlul_pkg::tl_d2h_t  D-channel response plus a_ready

Behaviour:
- All state registers update on posedge clk_i.
- When rst_i=1 at posedge:
  - state←IDLE, all output registers cleared.
  - Outputs: a_valid=0, d_ready=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, rsp_timeout_o=0, spurious_o=0.
  - cmd_ready_o=0 while rst_i is high.
  - Reset mid-transaction drops the transaction silently; no response is produced.
- FSM states: IDLE, A_REQ, D_WAIT, RSP.
- IDLE:
  - cmd_ready_o=1, d_ready=1.
  - On cmd_valid_i: latch the command and go to A_REQ next cycle.
  - A d_valid in IDLE → spurious_o pulses for 1 cycle and the beat is discarded.
- A_REQ:
  - a_valid=1; a_address={addr[31:2],2'b00}; a_size=2; a_source=SourceId.
  - a_opcode and a_mask:
    - Get(4) with a_mask=4'hF for reads.
    - PutFullData(0) when mask==4'hF.
    - PutPartialData(1) otherwise.
  - a_data=wdata for writes, 0 for reads; a_param=0; a_user=TL_A_USER_DEFAULT.
  - All A fields are held stable until a_ready. No timeout here: a_valid is never withdrawn.
  - a_valid&a_ready → D_WAIT, timeout counter←0.
- D_WAIT:
  - d_ready=1; counter increments each cycle without d_valid.
  - On d_valid, capture and go to RSP:
    - rsp_err = d_error | (d_source≠SourceId) | (opcode≠AccessAckData(1) for read / AccessAck(0) for write).
    - rdata = d_data if read and not err, else 0.
  - counter==TimeoutCycles-1 with no d_valid → RSP with err=1, timeout=1, rdata=0.
  - d_valid on the same cycle the counter expires: the response wins; no timeout.
- RSP:
  - rsp_valid_o=1 with stable fields; d_ready=0.
  - rsp_ready_i → IDLE.
  - Minimum command-to-command period: 4 cycles (IDLE→A_REQ→D_WAIT→RSP), given a_ready and d_valid each in 1 cycle.
- A late D beat after a timeout lands in IDLE and is flagged spurious. It is never matched to a later command.
- At most one transaction is outstanding at any time.

Test Plan:
1. Write addr 0x0000_0010, data 0xDEADBEEF, mask 4'hF, a_ready=1, AccessAck next cycle:
   - a_opcode=0, a_mask=F, a_address=0x10.
   - rsp_valid with err=0, rdata=0.
   - 4 cycles from cmd to rsp_valid.
2. Read addr 0x0000_0027, device returns AccessAckData d_data=0x1234_5678:
   - a_opcode=4, a_address=0x24.
   - rsp_rdata=0x12345678, err=0.
3. Write mask 4'b0011, a_ready held low 5 cycles:
   - a_opcode=1.
   - A fields stable all 5 cycles; no timeout.
4. Read with d_error=1, then a read with d_source=SourceId+1:
   - both give rsp_err=1, rdata=0, timeout=0.
5. Read with TimeoutCycles=8, no response:
   - rsp_err=1, rsp_timeout=1 on the 8th D_WAIT cycle.
   - A D beat injected afterwards in IDLE → spurious_o=1 for one cycle.
6. rst_i asserted in D_WAIT, then response arrives:
   - no rsp_valid; all outputs 0 the cycle after reset.
   - Beat arriving after reset release in IDLE → spurious_o.
